// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller.
//   state_t : 3-bit FSM state encoding, also presented on gameState
//   SCORE_W : width of each player's score
//   TIMER_W : width of the frame delay counter
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_PAUSE     = 3'd5
    } state_t;

endpackage

// File: rtl/frame_timer.sv
// Frame delay counter used by SERVE and POINT.
//   i_clk        : clock (rising edge)
//   i_rst        : synchronous active-high reset, clears the count
//   i_load_value : number of frames to count
//   i_load       : loads i_load_value; a frame tick in the same cycle is dropped
//   i_frame_tick : one-cycle pulse per frame
//   o_expired    : combinational pulse on the tick that completes the count
module frame_timer
    import pong_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [TIMER_W-1:0] i_load_value,
    input  logic               i_load,
    input  logic               i_frame_tick,
    output logic               o_expired
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_value;
        else if (i_frame_tick && r_count != '0)
            r_count <= r_count - 1'b1;
    end

    // Fires on the tick that takes the count from 1 to 0, so the FSM moves
    // in the same cycle as the last counted frame.
    assign o_expired = i_frame_tick && !i_load && (r_count == TIMER_W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: Moore FSM sequencing serve, play, point scoring and
// game over, driving paddle/ball reset and enable controls.
// Optional feature: define PONG_PAUSE_EN to allow pausing from PLAY.
//   pixelClock                : sole clock
//   Reset                     : synchronous active-high reset
//   start, pause              : level buttons, edge detected internally
//   frameTick                 : one pulse per frame
//   ballMissLeft/Right        : one-cycle miss pulses from the ball logic
//   paddleReset/paddleEnable  : paddle controls
//   ballReset/ballEnable      : ball controls
//   scoreLeft/scoreRight      : player scores
//   gameState                 : current state encoding
//   winnerLeft/winnerRight    : winning side, valid in GAME_OVER only
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int winScore         = 7,
    parameter int serveDelayFrames = 60,
    parameter int pointDelayFrames = 90
) (
    input  logic               pixelClock,
    input  logic               Reset,
    input  logic               start,
    input  logic               pause,
    input  logic               frameTick,
    input  logic               ballMissLeft,
    input  logic               ballMissRight,
    output logic               paddleReset,
    output logic               paddleEnable,
    output logic               ballReset,
    output logic               ballEnable,
    output logic [SCORE_W-1:0] scoreLeft,
    output logic [SCORE_W-1:0] scoreRight,
    output logic [2:0]         gameState,
    output logic               winnerLeft,
    output logic               winnerRight
);

    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(winScore);

    state_t             r_state;
    state_t             w_next;
    logic               r_startQ;
    logic               r_pauseQ;
    logic               r_entry;
    logic [SCORE_W-1:0] r_scoreLeft;
    logic [SCORE_W-1:0] r_scoreRight;
    logic               w_startEdge;
    logic               w_pauseEdge;
    logic               w_startGame;
    logic               w_load;
    logic [TIMER_W-1:0] w_loadValue;
    logic               w_expired;

    assign w_startEdge = start && !r_startQ;
    assign w_pauseEdge = pause && !r_pauseQ;
    assign w_startGame = w_startEdge && (r_state == ST_IDLE || r_state == ST_GAME_OVER);

    // Timer is loaded in the first cycle of SERVE/POINT; r_entry marks that
    // cycle, and the load masks any tick arriving in it.
    assign w_load      = r_entry && (r_state == ST_SERVE || r_state == ST_POINT);
    assign w_loadValue = (r_state == ST_SERVE) ? TIMER_W'(serveDelayFrames)
                                               : TIMER_W'(pointDelayFrames);

    frame_timer u_frame_timer (
        .i_clk        (pixelClock),
        .i_rst        (Reset),
        .i_load_value (w_loadValue),
        .i_load       (w_load),
        .i_frame_tick (frameTick),
        .o_expired    (w_expired)
    );

    always_ff @(posedge pixelClock) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_startQ <= 1'b0;
            r_pauseQ <= 1'b0;
            r_entry  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_startQ <= start;
            r_pauseQ <= pause;
            r_entry  <= (w_next != r_state);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_GAME_OVER: if (w_startEdge) w_next = ST_SERVE;
            ST_SERVE:              if (w_expired)   w_next = ST_PLAY;
            ST_PLAY: begin
                // A miss wins over a simultaneous pause edge.
                if (ballMissLeft || ballMissRight)
                    w_next = ST_POINT;
`ifdef PONG_PAUSE_EN
                else if (w_pauseEdge)
                    w_next = ST_PAUSE;
`endif
            end
            ST_POINT: begin
                if (w_expired)
                    w_next = (r_scoreLeft == WIN_SCORE || r_scoreRight == WIN_SCORE)
                             ? ST_GAME_OVER : ST_SERVE;
            end
            // Only reachable when pausing is built in.
            ST_PAUSE:              if (w_pauseEdge) w_next = ST_PLAY;
            default:               w_next = ST_IDLE;
        endcase
    end

    // Simultaneous misses award nothing; scores saturate at WIN_SCORE.
    always_ff @(posedge pixelClock) begin
        if (Reset || w_startGame) begin
            r_scoreLeft  <= '0;
            r_scoreRight <= '0;
        end else if (r_state == ST_PLAY && (ballMissLeft ^ ballMissRight)) begin
            if (ballMissLeft && r_scoreRight < WIN_SCORE)
                r_scoreRight <= r_scoreRight + 1'b1;
            if (ballMissRight && r_scoreLeft < WIN_SCORE)
                r_scoreLeft <= r_scoreLeft + 1'b1;
        end
    end

    always_comb begin
        paddleReset  = 1'b0;
        paddleEnable = 1'b0;
        ballReset    = 1'b0;
        ballEnable   = 1'b0;
        winnerLeft   = 1'b0;
        winnerRight  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                paddleReset = 1'b1;
                ballReset   = 1'b1;
            end
            ST_SERVE: begin
                ballReset    = 1'b1;
                paddleEnable = 1'b1;
            end
            ST_PLAY: begin
                ballEnable   = 1'b1;
                paddleEnable = 1'b1;
            end
            ST_POINT: paddleEnable = 1'b1;
            ST_GAME_OVER: begin
                paddleReset = 1'b1;
                ballReset   = 1'b1;
                winnerLeft  = (r_scoreLeft == WIN_SCORE);
                winnerRight = (r_scoreRight == WIN_SCORE);
            end
            default: ;
        endcase
    end

    assign scoreLeft  = r_scoreLeft;
    assign scoreRight = r_scoreRight;
    assign gameState  = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: directed game scenarios followed by random
// stimulus, checked cycle by cycle against a behavioural game model through
// an expected-output queue.
module tb_pong_game_ctrl;

    localparam int WIN = 7;
    localparam int SD  = 60;
    localparam int PD  = 90;
`ifdef PONG_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic       pixelClock = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       frameTick = 1'b0;
    logic       ballMissLeft = 1'b0;
    logic       ballMissRight = 1'b0;
    logic       paddleReset, paddleEnable, ballReset, ballEnable;
    logic [3:0] scoreLeft, scoreRight;
    logic [2:0] gameState;
    logic       winnerLeft, winnerRight;

    pong_game_ctrl #(
        .winScore         (WIN),
        .serveDelayFrames (SD),
        .pointDelayFrames (PD)
    ) dut (
        .pixelClock    (pixelClock),
        .Reset         (Reset),
        .start         (start),
        .pause         (pause),
        .frameTick     (frameTick),
        .ballMissLeft  (ballMissLeft),
        .ballMissRight (ballMissRight),
        .paddleReset   (paddleReset),
        .paddleEnable  (paddleEnable),
        .ballReset     (ballReset),
        .ballEnable    (ballEnable),
        .scoreLeft     (scoreLeft),
        .scoreRight    (scoreRight),
        .gameState     (gameState),
        .winnerLeft    (winnerLeft),
        .winnerRight   (winnerRight)
    );

    always #5 pixelClock = ~pixelClock;

    typedef struct packed {
        logic       pr, pe, br, be;
        logic [3:0] sl, sr;
        logic [2:0] gs;
        logic       wl, wr;
    } obs_t;

    obs_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural game model: mode uses the documented state numbers,
    // frames are counted upward from entry into SERVE/POINT.
    int m_mode = 0, m_sl = 0, m_sr = 0, m_ticks = 0;
    bit m_entry = 0, m_ps = 0, m_pp = 0;

    function automatic obs_t expect_now();
        obs_t o;
        o = '0;
        o.sl = m_sl[3:0];
        o.sr = m_sr[3:0];
        o.gs = m_mode[2:0];
        case (m_mode)
            0: begin o.pr = 1; o.br = 1; end
            1: begin o.br = 1; o.pe = 1; end
            2: begin o.be = 1; o.pe = 1; end
            3: o.pe = 1;
            4: begin
                o.pr = 1; o.br = 1;
                o.wl = (m_sl == WIN);
                o.wr = (m_sr == WIN);
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic enter_timed(input int mode);
        m_mode  = mode;
        m_ticks = 0;
        m_entry = 1;
    endtask

    task automatic count_frame(input bit tk, input int lim, output bit done);
        done = 0;
        if (m_entry) m_entry = 0;          // first cycle of the state never counts
        else if (tk) begin
            m_ticks++;
            done = (m_ticks == lim);
        end
    endtask

    task automatic model_step(input bit rst, st, pa, tk, ml, mr);
        bit se, pe, done;
        if (rst) begin
            m_mode = 0; m_sl = 0; m_sr = 0; m_ticks = 0;
            m_entry = 0; m_ps = 0; m_pp = 0;
            return;
        end
        se = st && !m_ps;
        pe = pa && !m_pp;
        m_ps = st;
        m_pp = pa;
        case (m_mode)
            0, 4: if (se) begin m_sl = 0; m_sr = 0; enter_timed(1); end
            1: begin
                count_frame(tk, SD, done);
                if (done) m_mode = 2;
            end
            2: begin
                if (ml || mr) begin
                    if (ml && !mr) m_sr = (m_sr < WIN) ? m_sr + 1 : WIN;
                    if (mr && !ml) m_sl = (m_sl < WIN) ? m_sl + 1 : WIN;
                    enter_timed(3);
                end else if (PAUSE_EN && pe) m_mode = 5;
            end
            3: begin
                count_frame(tk, PD, done);
                if (done) begin
                    if (m_sl == WIN || m_sr == WIN) m_mode = 4;
                    else enter_timed(1);
                end
            end
            5: if (pe) m_mode = 2;
            default: m_mode = 0;
        endcase
    endtask

    task automatic cyc(input bit rst, st, pa, tk, ml, mr);
        @(negedge pixelClock);
        Reset = rst; start = st; pause = pa;
        frameTick = tk; ballMissLeft = ml; ballMissRight = mr;
        model_step(rst, st, pa, tk, ml, mr);
        q.push_back(expect_now());
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(0, 0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 0, 0);
        end
    endtask

    // Start press followed by a frame tick in the SERVE entry cycle.
    task automatic press_start();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
    endtask

    always @(posedge pixelClock) begin : monitor
        obs_t e, a;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            a = {paddleReset, paddleEnable, ballReset, ballEnable,
                 scoreLeft, scoreRight, gameState, winnerLeft, winnerRight};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d outputs: got pr%b pe%b br%b be%b L%0d R%0d st%0d wl%b wr%b, want pr%b pe%b br%b be%b L%0d R%0d st%0d wl%b wr%b",
                         vectors, a.pr, a.pe, a.br, a.be, a.sl, a.sr, a.gs, a.wl, a.wr,
                         e.pr, e.pe, e.br, e.be, e.sl, e.sr, e.gs, e.wl, e.wr);
            end
        end
    end

    initial begin
        // reset and first serve
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1, 1);              // reset beats every other input
        idle(3);
        press_start();
        ticks(SD);
        idle(2);
        // right miss scores left, point delay back to serve
        cyc(0, 0, 0, 0, 0, 1);
        ticks(PD);
        // play out to a left win
        repeat (WIN - 1) begin
            ticks(SD);
            cyc(0, 0, 0, 0, 0, 1);
            ticks(PD);
        end
        idle(2);
        cyc(0, 0, 0, 0, 1, 0);              // miss in GAME_OVER ignored
        press_start();
        // simultaneous misses, then reset mid-POINT with 40 frames left
        ticks(SD);
        cyc(0, 0, 0, 0, 1, 1);
        ticks(PD - 40);
        cyc(1, 0, 0, 0, 0, 0);
        idle(2);
        // pause sequence (ignored unless pausing is built in)
        press_start();
        ticks(SD);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);              // pause edge and miss together
        idle(3);
        // random play
        repeat (8000)
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge pixelClock);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
